// File: rtl/program_loader_if.sv
// Boot loader bus bundle.
//   Byte stream (valid/ready): Byte_i, Byte_Valid_i from the source,
//                              Byte_Ready_o from the loader.
//   Program-memory write port: Mem_Write_o, Mem_Address_o, Mem_Data_o
//                              from the loader.
// master = stream source / memory side, slave = the loader itself.
interface program_loader_if;
    logic [7:0]  Byte_i;
    logic        Byte_Valid_i;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;

    modport master (
        output Byte_i, Byte_Valid_i,
        input  Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o
    );

    modport slave (
        input  Byte_i, Byte_Valid_i,
        output Byte_Ready_o, Mem_Write_o, Mem_Address_o, Mem_Data_o
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. Parses the frame
//   A5, N[7:0], N[15:8], 4*N payload bytes (LSB first per word), checksum
// and writes each assembled word to program memory at byte address 4*k.
// The core is held in reset until a frame with a good checksum is loaded.
// Ports:
//   clk, reset         clock, async active-high reset
//   bus (slave)        byte stream in, program-memory write port out
//   Core_Reset_o       core reset, low only after a verified load
//   Done_o / Error_o   sticky load-complete / frame-rejected flags
module program_loader #(
    parameter int PROGRAM_MEMORY_DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             Core_Reset_o,
    output logic             Done_o,
    output logic             Error_o
);

    // Word counters only need to hold 0..PROGRAM_MEMORY_DEPTH.
    localparam int IDX_W = $clog2(PROGRAM_MEMORY_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       len_lo;
    logic [IDX_W-1:0] word_count;
    logic [IDX_W-1:0] word_index;
    logic [IDX_W-1:0] word_index_inc;
    logic [1:0]       lane;
    logic [7:0]       sum;
    logic [7:0]       sum_chk;
    logic [23:0]      word_buf;
    logic [15:0]      len_full;
    logic             accept;
    logic             last_word;

    // Outputs decoded straight from the state register: no path from the
    // stream inputs to any output.
    assign bus.Byte_Ready_o = (state == IDLE) || (state == LEN_LO) || (state == LEN_HI)
                           || (state == DATA) || (state == CHECK);
    assign Done_o       = (state == DONE);
    assign Error_o      = (state == ERROR);
    assign Core_Reset_o = (state != DONE);

    assign accept         = bus.Byte_Valid_i && bus.Byte_Ready_o;
    assign len_full       = {bus.Byte_i, len_lo};
    assign word_index_inc = word_index + IDX_W'(1);
    assign last_word      = (word_index_inc == word_count);
    assign sum_chk        = sum + bus.Byte_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept && bus.Byte_i == 8'hA5) state_nxt = LEN_LO;
            LEN_LO: if (accept) state_nxt = LEN_HI;
            LEN_HI: if (accept) begin
                if (len_full > 16'(PROGRAM_MEMORY_DEPTH)) state_nxt = ERROR;
                else if (len_full == 16'd0)               state_nxt = CHECK;
                else                                      state_nxt = DATA;
            end
            DATA:   if (accept && lane == 2'd3 && last_word) state_nxt = CHECK;
            CHECK:  if (accept) state_nxt = (sum_chk == 8'h00) ? DONE : ERROR;
            default: state_nxt = state;
        endcase
    end

    // Datapath: length capture, byte assembly, running sum, write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo            <= '0;
            word_count        <= '0;
            word_index        <= '0;
            lane              <= '0;
            sum               <= '0;
            word_buf          <= '0;
            bus.Mem_Write_o   <= 1'b0;
            bus.Mem_Address_o <= '0;
            bus.Mem_Data_o    <= '0;
        end else begin
            bus.Mem_Write_o <= 1'b0;
            if (accept) begin
                case (state)
                    LEN_LO: len_lo <= bus.Byte_i;
                    // Out-of-range counts go to ERROR, so truncation is harmless.
                    LEN_HI: word_count <= IDX_W'(len_full);
                    DATA: begin
                        sum  <= sum + bus.Byte_i;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: word_buf[7:0]   <= bus.Byte_i;
                            2'd1: word_buf[15:8]  <= bus.Byte_i;
                            2'd2: word_buf[23:16] <= bus.Byte_i;
                            default: begin
                                // Top byte goes straight to the write port.
                                bus.Mem_Data_o    <= {bus.Byte_i, word_buf};
                                bus.Mem_Address_o <= {{(30-IDX_W){1'b0}}, word_index, 2'b00};
                                bus.Mem_Write_o   <= 1'b1;
                                word_index        <= word_index_inc;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal load, bad checksum, empty
// image with and without stream gaps, oversized count, reset mid-load.
module tb_program_loader;

    logic clk;
    logic reset;
    logic Core_Reset_o, Done_o, Error_o;
    int   tests;
    int   fails;
    int   base;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    program_loader_if bus ();

    program_loader #(.PROGRAM_MEMORY_DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .Core_Reset_o (Core_Reset_o),
        .Done_o       (Done_o),
        .Error_o      (Error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.Mem_Write_o === 1'b1) begin
            q_addr.push_back(bus.Mem_Address_o);
            q_data.push_back(bus.Mem_Data_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.Byte_i       = b;
        bus.Byte_Valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.Byte_Valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_nominal_head();
        send(8'hA5); send(8'h02); send(8'h00);
    endtask

    task automatic send_nominal_body(input logic [7:0] csum);
        send(8'h93); send(8'h00); send(8'h50); send(8'h00);
        send(8'h33); send(8'h81); send(8'h10); send(8'h00);
        send(csum);
    endtask

    initial begin
        logic [7:0] empty_stream [6];
        tests = 0;
        fails = 0;
        empty_stream = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        bus.Byte_i       = 8'h00;
        bus.Byte_Valid_i = 1'b0;
        reset            = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready",     32'(bus.Byte_Ready_o), 32'd1);
        chk("rst_write",     32'(bus.Mem_Write_o),  32'd0);
        chk("rst_addr",      bus.Mem_Address_o,     32'd0);
        chk("rst_data",      bus.Mem_Data_o,        32'd0);
        chk("rst_core_rst",  32'(Core_Reset_o),     32'd1);
        chk("rst_done",      32'(Done_o),           32'd0);
        chk("rst_error",     32'(Error_o),          32'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal load with strobe timing checked cycle by cycle.
        base = q_addr.size();
        send_nominal_head();
        send(8'h93); send(8'h00); send(8'h50); send(8'h00);
        chk("nom_w0_strobe", 32'(bus.Mem_Write_o), 32'd1);
        chk("nom_w0_addr",   bus.Mem_Address_o,    32'h0000_0000);
        chk("nom_w0_data",   bus.Mem_Data_o,       32'h0050_0093);
        send(8'h33);
        chk("nom_strobe_low", 32'(bus.Mem_Write_o), 32'd0);
        chk("nom_data_hold",  bus.Mem_Data_o,       32'h0050_0093);
        send(8'h81); send(8'h10); send(8'h00);
        chk("nom_w1_strobe", 32'(bus.Mem_Write_o), 32'd1);
        chk("nom_w1_addr",   bus.Mem_Address_o,    32'h0000_0004);
        chk("nom_w1_data",   bus.Mem_Data_o,       32'h0010_8133);
        chk("nom_pre_done",  32'(Done_o),          32'd0);
        chk("nom_pre_ready", 32'(bus.Byte_Ready_o), 32'd1);
        send(8'h59);
        chk("nom_done",      32'(Done_o),           32'd1);
        chk("nom_core_rst",  32'(Core_Reset_o),     32'd0);
        chk("nom_ready",     32'(bus.Byte_Ready_o), 32'd0);
        chk("nom_error",     32'(Error_o),          32'd0);
        idle(2);
        chk("nom_nwrites",   32'(q_addr.size() - base), 32'd2);
        chk("nom_addr_hold", bus.Mem_Address_o,     32'h0000_0004);

        // Asynchronous reset mid-cycle from DONE.
        #2 reset = 1'b1;
        #1;
        chk("async_ready",    32'(bus.Byte_Ready_o), 32'd1);
        chk("async_core_rst", 32'(Core_Reset_o),     32'd1);
        chk("async_done",     32'(Done_o),           32'd0);
        chk("async_addr",     bus.Mem_Address_o,     32'd0);
        chk("async_data",     bus.Mem_Data_o,        32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Bad checksum: writes still happen, then ERROR.
        base = q_addr.size();
        send_nominal_head();
        send_nominal_body(8'h58);
        chk("bad_error",    32'(Error_o),          32'd1);
        chk("bad_core_rst", 32'(Core_Reset_o),     32'd1);
        chk("bad_done",     32'(Done_o),           32'd0);
        chk("bad_ready",    32'(bus.Byte_Ready_o), 32'd0);
        idle(2);
        chk("bad_nwrites",  32'(q_addr.size() - base), 32'd2);
        chk("bad_w0_addr",  q_addr[base],          32'h0000_0000);
        chk("bad_w1_data",  q_data[base+1],        32'h0010_8133);
        apply_reset();

        // Garbage then empty image, back to back.
        base = q_addr.size();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("empty_pre_done", 32'(Done_o), 32'd0);
            send(empty_stream[i]);
        end
        chk("empty_done",     32'(Done_o),       32'd1);
        chk("empty_core_rst", 32'(Core_Reset_o), 32'd0);
        idle(2);
        chk("empty_nwrites",  32'(q_addr.size() - base), 32'd0);
        apply_reset();

        // Same stream with random valid gaps.
        base = q_addr.size();
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, 3));
            send(empty_stream[i]);
        end
        chk("gap_done",     32'(Done_o),       32'd1);
        chk("gap_error",    32'(Error_o),      32'd0);
        idle(2);
        chk("gap_nwrites",  32'(q_addr.size() - base), 32'd0);
        apply_reset();

        // Oversized count: N = 65.
        base = q_addr.size();
        send(8'hA5); send(8'h41);
        chk("big_pre_error", 32'(Error_o), 32'd0);
        send(8'h00);
        chk("big_error",    32'(Error_o),          32'd1);
        chk("big_ready",    32'(bus.Byte_Ready_o), 32'd0);
        for (int i = 0; i < 8; i++) send(8'h11 * 8'(i));
        chk("big_nwrites",  32'(q_addr.size() - base), 32'd0);
        chk("big_done",     32'(Done_o),           32'd0);
        chk("big_core_rst", 32'(Core_Reset_o),     32'd1);
        apply_reset();

        // Reset after 5 payload bytes, then full resend.
        send_nominal_head();
        send(8'h93); send(8'h00); send(8'h50); send(8'h00); send(8'h33);
        apply_reset();
        chk("mid_rst_ready", 32'(bus.Byte_Ready_o), 32'd1);
        chk("mid_rst_addr",  bus.Mem_Address_o,     32'd0);
        base = q_addr.size();
        send_nominal_head();
        send_nominal_body(8'h59);
        chk("mid_done",     32'(Done_o), 32'd1);
        idle(2);
        chk("mid_nwrites",  32'(q_addr.size() - base), 32'd2);
        chk("mid_w0_addr",  q_addr[base],   32'h0000_0000);
        chk("mid_w0_data",  q_data[base],   32'h0050_0093);
        chk("mid_w1_addr",  q_addr[base+1], 32'h0000_0004);
        chk("mid_w1_data",  q_data[base+1], 32'h0010_8133);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the single-cycle core's program memory. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them into program memory through a dedicated write port, starting at byte address 0, and holds the core in reset until a complete, checksum-verified image has been written.

## Interface
- PROGRAM_MEMORY_DEPTH, 64, program memory size in 32-bit words; largest accepted word count.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Byte_i  input  8  incoming stream byte.
- Byte_Valid_i  input  1  Byte_i is valid this cycle.
- Byte_Ready_o  output  1  loader accepts a byte this cycle; transfer occurs when Byte_Valid_i & Byte_Ready_o.
- Mem_Write_o  output  1  one-cycle program-memory write strobe.
- Mem_Address_o  output  32  byte address of the write; word aligned, same addressing as the PC.
- Mem_Data_o  output  32  instruction word to write.
- Core_Reset_o  output  1  reset to the core; high until a successful load.
- Done_o  output  1  image loaded and verified (sticky).
- Error_o  output  1  frame rejected (sticky).

## Operation
- Frame: sync 0xA5, count low byte, count high byte (N, 16-bit), 4·N payload bytes (each word LSB first), checksum byte C. The frame is valid when (sum of payload bytes + C) mod 256 = 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE: accepted bytes other than 0xA5 are discarded. Accepting 0xA5 moves to LEN_LO.
- LEN_LO → LEN_HI on each accepted byte. The LEN_HI transition depends on the assembled N:
  - N > PROGRAM_MEMORY_DEPTH → ERROR.
  - N = 0 → CHECK.
  - otherwise → DATA.
- DATA: shift each accepted byte into a 32-bit word at lane (byte_count mod 4). Add every byte to an 8-bit running sum, with wrap-around.
  - On the 4th byte of a word, register the word and address word_index·4, and pulse Mem_Write_o. Then increment word_index.
  - After word N−1 is completed → CHECK.
- CHECK: on the accepted byte, (sum + byte) mod 256 = 0 → DONE, else → ERROR.
- DONE: Byte_Ready_o=0, Done_o=1, Core_Reset_o=0. Remains here until reset.
- ERROR: Byte_Ready_o=0, Error_o=1, Core_Reset_o=1. Remains here until reset.
- Bytes already written before an error are not cleared.
- Byte_Ready_o=1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK. It never stalls mid-frame; gaps in Byte_Valid_i are tolerated at any point.
- Reset at any time, including mid-frame:
  - Return to IDLE.
  - Clear counters, running sum and word buffer.
  - Memory contents are untouched.

## Timing
- Reset values: Byte_Ready_o=1, Mem_Write_o=0, Mem_Address_o=0, Mem_Data_o=0, Core_Reset_o=1, Done_o=0, Error_o=0.
- All outputs are registered or decoded directly from the state register. No combinational path from Byte_i or Byte_Valid_i to any output.
- 4th byte of word k accepted at edge t: Mem_Write_o=1 with Mem_Address_o=4k and the full word during cycle t→t+1, and low the next cycle unless another word completes.
- Throughput: one byte per cycle. Back-to-back words produce a write strobe every 4th cycle.
- Checksum byte accepted at edge t: Done_o (or Error_o) rises and Core_Reset_o falls (or stays high) right after edge t. Byte_Ready_o falls in the same cycle.
- Oversized-N error is asserted right after the edge that accepts the count high byte. No write strobes occur for that frame.
- Mem_Address_o and Mem_Data_o hold their last values between strobes.

## Test plan
- Reset check: assert reset asynchronously mid-cycle → all outputs take their reset values immediately; Core_Reset_o=1.
- Nominal load: stream A5 02 00 93 00 50 00 33 81 10 00 59 → two strobes:
  - addr 0x00000000, data 0x00500093.
  - addr 0x00000004, data 0x00108133.
  - One cycle after 0x59: Done_o=1, Core_Reset_o=0, Byte_Ready_o=0.
- Bad checksum: same stream ending in 0x58 → both writes still occur; then Error_o=1, Core_Reset_o stays 1, Done_o=0.
- Garbage and empty image: stream 00 FF A5 00 00 00 → no Mem_Write_o pulses; Done_o=1 after the final byte. Repeat with random Byte_Valid_i gaps and require identical results.
- Oversized image: A5 41 00 (N=65, depth 64) → Error_o=1 right after the edge accepting 0x00; no strobes; later bytes are not accepted.
- Reset mid-load: assert reset after 5 payload bytes of the nominal stream, then resend the full stream → exactly two strobes at addr 0 and 4 with the nominal data; Done_o=1.
